// File: rtl/pc_pkg.sv
// Shared types and defaults for the program-counter stage.
package pc_pkg;

  localparam int PC_W_DEF     = 8;
  localparam int RESET_PC_DEF = 0;

  // Source selected for the next program-counter value.
  typedef enum logic [2:0] {
    NPC_SEQ,
    NPC_BRANCH,
    NPC_JUMP,
    NPC_CALL,
    NPC_RET,
    NPC_HOLD
  } npc_src_e;

  // Sequencer run state.
  typedef enum logic {
    ST_RUN,
    ST_HALTED
  } pc_state_e;

endpackage

// File: rtl/ras_stack.sv
// Return-address stack: LIFO that overwrites its oldest entry when pushed while full.
module ras_stack #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] push_data,
  output logic [DATA_W-1:0] top,
  output logic              empty,
  output logic              full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  sp_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [PTR_W-1:0]  top_idx;

  // sp_q points at the next slot to write; the newest entry sits just below it,
  // and the pointer wraps so a push into a full stack lands on the oldest entry.
  assign top_idx = sp_q - PTR_W'(1);
  assign top     = mem_q[top_idx];
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CNT_W'(DEPTH));

  // Stack pointer and occupancy; a pop wins if both are requested.
  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q  <= '0;
      cnt_q <= '0;
    end else if (pop && !empty) begin
      sp_q  <= sp_q - PTR_W'(1);
      cnt_q <= cnt_q - CNT_W'(1);
    end else if (push && !pop) begin
      sp_q <= sp_q + PTR_W'(1);
      if (!full) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Entry storage; contents are meaningless while the count says empty, so no reset.
  always_ff @(posedge clk) begin
    if (push && !pop) mem_q[sp_q] <= push_data;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter stage: PC register, next-PC priority select, RUN/HALTED FSM,
// return-address stack and sticky stack-error flags.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int PC_W      = PC_W_DEF,
  parameter int RESET_PC  = RESET_PC_DEF,
  parameter int RAS_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   branch_sel,
  input  logic signed [PC_W-1:0] branch_off,
  input  logic                   jump,
  input  logic [PC_W-1:0]        jump_addr,
  input  logic                   call,
  input  logic                   ret,
  input  logic                   halt,
  output logic [PC_W-1:0]        pc,
  output logic [PC_W-1:0]        pc_plus1,
  output logic                   halted,
  output logic                   ras_overflow,
  output logic                   ras_underflow
);

  pc_state_e       state_q, state_d;
  npc_src_e        npc_src;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;
  logic            ras_push, ras_pop;
  logic [PC_W-1:0] ras_top;
  logic            ras_empty, ras_full;

  assign pc            = pc_q;
  assign pc_plus1      = pc_q + PC_W'(1);
  assign halted        = (state_q == ST_HALTED);
  assign ras_overflow  = ovf_q;
  assign ras_underflow = unf_q;

  ras_stack #(
    .DATA_W (PC_W),
    .DEPTH  (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_plus1),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  // Priority select of the next-PC source, then next state, stack control and flags.
  always_comb begin
    npc_src  = NPC_HOLD;
    state_d  = state_q;
    pc_d     = pc_q;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    ovf_d    = ovf_q;
    unf_d    = unf_q;

    if (state_q == ST_RUN && en) begin
      if (halt)            npc_src = NPC_HOLD;
      else if (ret)        npc_src = NPC_RET;
      else if (call)       npc_src = NPC_CALL;
      else if (jump)       npc_src = NPC_JUMP;
      else if (branch_sel) npc_src = NPC_BRANCH;
      else                 npc_src = NPC_SEQ;
      if (halt) state_d = ST_HALTED;
    end

    case (npc_src)
      NPC_SEQ:    pc_d = pc_plus1;
      NPC_BRANCH: pc_d = pc_plus1 + $unsigned(branch_off);
      NPC_JUMP:   pc_d = jump_addr;
      NPC_CALL: begin
        ras_push = 1'b1;
        pc_d     = jump_addr;
        if (ras_full) ovf_d = 1'b1;
      end
      NPC_RET: begin
        if (!ras_empty) begin
          ras_pop = 1'b1;
          pc_d    = ras_top;
        end else begin
          pc_d  = pc_plus1;
          unf_d = 1'b1;
        end
      end
      default:    pc_d = pc_q;
    endcase
  end

  // State, PC and sticky flag registers; reset overrides stall and HALTED.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      pc_q    <= PC_W'(RESET_PC);
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer (PC_W=8, RESET_PC=0, RAS_DEPTH=4).
module tb_pc_sequencer;

  logic              clk = 1'b0;
  logic              reset, en, branch_sel, jump, call, ret, halt;
  logic signed [7:0] branch_off;
  logic [7:0]        jump_addr;
  logic [7:0]        pc, pc_plus1;
  logic              halted, ras_overflow, ras_underflow;

  int checks = 0;
  int errors = 0;

  pc_sequencer #(
    .PC_W      (8),
    .RESET_PC  (0),
    .RAS_DEPTH (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .en            (en),
    .branch_sel    (branch_sel),
    .branch_off    (branch_off),
    .jump          (jump),
    .jump_addr     (jump_addr),
    .call          (call),
    .ret           (ret),
    .halt          (halt),
    .pc            (pc),
    .pc_plus1      (pc_plus1),
    .halted        (halted),
    .ras_overflow  (ras_overflow),
    .ras_underflow (ras_underflow)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1 time unit before checking or driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle();
    branch_sel = 0; branch_off = '0; jump = 0; jump_addr = '0;
    call = 0; ret = 0; halt = 0;
  endtask

  task automatic go_jump(input logic [7:0] a);
    idle(); jump = 1; jump_addr = a; step(); idle();
  endtask

  task automatic do_call(input logic [7:0] a);
    idle(); call = 1; jump_addr = a; step(); idle();
  endtask

  task automatic do_ret();
    idle(); ret = 1; step(); idle();
  endtask

  initial begin
    idle();
    reset = 1; en = 0;
    step();
    chk("rst_pc", pc, 0);
    chk("rst_pc_plus1", pc_plus1, 1);
    chk("rst_halted", halted, 0);
    chk("rst_ovf", ras_overflow, 0);
    chk("rst_unf", ras_underflow, 0);

    // Sequential stepping
    reset = 0; en = 1;
    step(); chk("seq1", pc, 1);
    step(); chk("seq2", pc, 2);
    step(); chk("seq3", pc, 3);

    // Wrap-around at 255
    go_jump(8'd255);
    chk("jump255", pc, 255);
    chk("plus1_wrap", pc_plus1, 0);
    step(); chk("seq_wrap", pc, 0);

    // Backward branch: 10 + 1 - 3 = 8
    go_jump(8'd10);
    branch_sel = 1; branch_off = 8'shFD; step(); idle();
    chk("branch_back", pc, 8);
    // Jump beats branch
    go_jump(8'd10);
    branch_sel = 1; branch_off = 8'shFD; jump = 1; jump_addr = 8'd40; step(); idle();
    chk("jump_over_branch", pc, 40);
    // Branch wrapping below zero: 1 + 1 - 3 = 255
    go_jump(8'd1);
    branch_sel = 1; branch_off = 8'shFD; step(); idle();
    chk("branch_wrap_down", pc, 255);
    // Branch wrapping above 255: 0 + 5 = 5
    branch_sel = 1; branch_off = 8'sh05; step(); idle();
    chk("branch_wrap_up", pc, 5);

    // Two-level call/return from pc=5
    do_call(8'd20); chk("call1", pc, 20);
    do_call(8'd50); chk("call2", pc, 50);
    do_ret();       chk("ret1", pc, 21);
    do_ret();       chk("ret2", pc, 6);
    chk("unf_after_pair", ras_underflow, 0);
    chk("ovf_after_pair", ras_overflow, 0);

    // Five nested calls into a 4-deep stack
    go_jump(8'd1);
    for (int i = 2; i <= 6; i++) begin
      do_call(8'(i));
      chk("nest_call", pc, i);
    end
    chk("ovf_set", ras_overflow, 1);
    chk("unf_clear_nest", ras_underflow, 0);
    for (int i = 6; i >= 3; i--) begin
      do_ret();
      chk("nest_ret", pc, i);
    end
    chk("unf_before_empty_pop", ras_underflow, 0);
    do_ret();
    chk("empty_ret_pc", pc, 4);
    chk("unf_set", ras_underflow, 1);

    // Halt at pc=7, then other requests and en toggling are ignored
    go_jump(8'd7);
    halt = 1; step(); idle();
    chk("halt_pc", pc, 7);
    chk("halt_flag", halted, 1);
    for (int i = 0; i < 10; i++) begin
      jump = i[0]; jump_addr = 8'd99; ret = i[1]; call = i[2]; en = ~i[0];
      step();
      chk("halted_pc", pc, 7);
      chk("halted_stay", halted, 1);
    end
    idle();

    // Reset with en=0 leaves HALTED and clears sticky flags
    en = 0; reset = 1; step(); reset = 0;
    chk("rst2_pc", pc, 0);
    chk("rst2_halted", halted, 0);
    chk("rst2_ovf", ras_overflow, 0);
    chk("rst2_unf", ras_underflow, 0);

    // halt ignored while stalled
    halt = 1; step(); idle();
    chk("stall_halt_ignored", halted, 0);
    chk("stall_pc", pc, 0);

    en = 1;
    step(); chk("post_rst_seq", pc, 1);

    // call+ret with empty stack: ret wins, underflow, nothing pushed
    call = 1; ret = 1; jump_addr = 8'd77; step(); idle();
    chk("callret_pc", pc, 2);
    chk("callret_unf", ras_underflow, 1);
    do_ret();
    chk("callret_no_push", pc, 3);

    // Stalled call neither moves pc nor pushes
    do_call(8'd30); chk("call30", pc, 30);
    en = 0; call = 1; jump_addr = 8'd99; step(); idle();
    chk("stall_call_pc", pc, 30);
    en = 1;
    do_ret(); chk("ret_after_stall", pc, 4);
    do_ret(); chk("ret_empty_after_stall", pc, 5);
    chk("ovf_still_clear", ras_overflow, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter stage of the 24-bit single-cycle CPU.
- Directly downstream of the control-flag select mux. It consumes that mux's 1-bit output as `branch_sel` and computes the next instruction address from it.
- Holds the PC register, a small return-address stack (RAS) for call/return, and a RUN/HALTED state machine.
- Drives the instruction-memory address every cycle.

Parameters:
- PC_W, 8, PC and instruction-address width in bits; arithmetic is modulo 2^PC_W.
- RESET_PC, 0, PC value loaded on reset.
- RAS_DEPTH, 4, return-address stack entries; must be a power of two, ≥2.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  advance enable; when low, all state holds (stall).
- branch_sel  in  1  branch-taken flag from the flag-select mux.
- branch_off  in  PC_W  signed branch offset, two's complement.
- jump  in  1  unconditional jump request.
- jump_addr  in  PC_W  absolute target for jump and call.
- call  in  1  call request: push return address, go to jump_addr.
- ret  in  1  return request: pop RAS into PC.
- halt  in  1  halt request.
- pc  out  PC_W  current instruction address.
- pc_plus1  out  PC_W  pc+1 mod 2^PC_W, combinational; link value.
- halted  out  1  high while in HALTED.
- ras_overflow  out  1  sticky; set on a push into a full RAS.
- ras_underflow  out  1  sticky; set on a pop from an empty RAS.

Behaviour:

Clocking and reset:
- One clock. Reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset takes priority over everything, including en=0 and the HALTED state.
- Reset values: pc=RESET_PC, state=RUN, halted=0, RAS empty (count=0), ras_overflow=0, ras_underflow=0.
- Reset mid-call-chain discards all stacked addresses.

States:
- RUN: the PC updates each cycle that en=1.
- HALTED: pc, RAS and flags are frozen. Only reset leaves this state.

In RUN with en=1, the next PC is chosen by this priority (highest first):
1. halt: pc unchanged; next state HALTED; halted=1 from the next cycle.
2. ret:
   - RAS non-empty: pc ← top entry; pop.
   - RAS empty: pc ← pc_plus1 and ras_underflow ← 1.
3. call:
   - push pc_plus1, then pc ← jump_addr.
   - If the RAS is full, the push overwrites the oldest entry (circular), count stays at RAS_DEPTH, and ras_overflow ← 1.
4. jump: pc ← jump_addr.
5. branch_sel: pc ← pc_plus1 + sext(branch_off), mod 2^PC_W.
6. Otherwise: pc ← pc_plus1.

Further rules:
- Lower-priority requests asserted in the same cycle are ignored (e.g. call+ret → ret only; jump+branch_sel → jump).
- en=0: no state change. Inputs are ignored, halt included.
- Latency: a request presented in cycle N is reflected on pc in cycle N+1. pc is a registered output. pc_plus1 follows pc combinationally.
- Wrap-around: pc at 2^PC_W−1 with a sequential step → 0. Branch arithmetic wraps in both directions.
- Sticky flags clear only on reset.

Decomposition:
- Shared package pc_pkg holds:
  - the next-PC source enum: NPC_SEQ, NPC_BRANCH, NPC_JUMP, NPC_CALL, NPC_RET, NPC_HOLD;
  - the state enum: ST_RUN, ST_HALTED;
  - default PC_W and RESET_PC constants.
- One sub-module, ras_stack:
  - parameterised LIFO with circular overwrite-on-full;
  - ports: clk, reset, push, pop, push_data, top, empty, full.
- The top level holds the PC register, the priority encoder, the FSM and the sticky flags.

Test Plan:
- Reset, then en=1 with no requests for 3 cycles → pc=0,1,2,3; with PC_W=8 and pc=255, the next step → pc=0.
- pc=10, branch_sel=1, branch_off=8'hFD (−3) → pc=8. Same stimulus with jump=1, jump_addr=40 → pc=40 (jump beats branch).
- pc=5: call jump_addr=20; then at pc=20 call jump_addr=50; then ret, ret → pc sequence 20, 50, 21, 6; ras_underflow=0.
- RAS_DEPTH=4: 5 nested calls from pc=1,2,3,4,5 (targets 2..6), then 5 rets → first four pops return 6,5,4,3; ras_overflow=1; fifth ret → pc_plus1 and ras_underflow=1.
- halt at pc=7 → pc stays 7 and halted=1 while jump/ret/en toggle for 10 cycles. Reset asserted with en=0 → next cycle pc=0, halted=0, flags clear.
- en=0 while call=1 → pc and RAS unchanged. Simultaneous call+ret with an empty RAS → pc_plus1, ras_underflow=1, nothing pushed.
